// File: rtl/trig_event_capture.sv
// Timestamps rising edges of the four trigger-FSM detect lines into a show-ahead
// event FIFO, latches the probe-B TOF word and stretches the delayed-trigger pulse.
module trig_event_capture #(
   parameter int TS_WIDTH   = 48,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          rxclk,
   input  logic                          rst,
   input  logic                          arm,
   input  logic [3:0]                    detect_pls,
   input  logic [31:0]                   pulse_tof,
   input  logic [31:0]                   out_width,
   output logic                          trig_out,
   output logic [31:0]                   tof_latched,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [1:0]                    rd_chan,
   output logic [TS_WIDTH-1:0]           rd_ts,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [CNT_WIDTH-1:0]          event_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = TS_WIDTH + 2;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Remaining cycles after the first high cycle; a zero width behaves as one.
   function automatic logic [31:0] pulse_len(input logic [31:0] w);
      return (w == 32'd0) ? 32'd0 : w - 32'd1;
   endfunction

   logic [TS_WIDTH-1:0] ts_p0;
   logic                arm_prev;
   logic [3:0]          detect_prev;
   logic                arm_rise;
   logic [3:0]          edge_p0;

   logic [3:0]          pend;
   logic [TS_WIDTH-1:0] pend_ts [4];
   logic                sel_vld;
   logic [1:0]          sel_idx;
   logic [3:0]          sel_oh;
   logic                pend_drop;

   logic                wr_vld_p1;
   logic [1:0]          wr_chan_p1;
   logic [TS_WIDTH-1:0] wr_ts_p1;

   logic [RW-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic                full;
   logic                pop;
   logic                push;
   logic [RW-1:0]       head;

   logic                tof_vld_p1;
   logic                trg_vld_p1;
   logic [31:0]         tof_p1;
   logic [31:0]         trig_cnt;

   assign arm_rise = arm & ~arm_prev;
   assign edge_p0  = detect_pls & ~detect_prev & {4{arm}};

   // ---- stage p0: edge detect, timestamp, pending capture ----
   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         ts_p0       <= '0;
         arm_prev    <= 1'b0;
         detect_prev <= '0;
      end else begin
         ts_p0       <= arm_rise ? '0 : ts_p0 + 1'b1;
         arm_prev    <= arm;
         detect_prev <= detect_pls;
      end
   end

   always_comb begin
      sel_idx = '0;
      sel_oh  = '0;
      for (int i = 3; i >= 0; i--) begin
         if (pend[i]) begin
            sel_idx    = 2'(i);
            sel_oh     = '0;
            sel_oh[i]  = 1'b1;
         end
      end
   end

   assign sel_vld   = |pend;
   // A re-edge on a channel not being drained this cycle loses its earlier timestamp.
   assign pend_drop = |(edge_p0 & pend & ~sel_oh);

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst)
         pend <= '0;
      else if (!arm)
         pend <= '0;
      else if (arm_rise)
         pend <= edge_p0;
      else
         pend <= (pend & ~sel_oh) | edge_p0;
   end

   always_ff @(posedge rxclk) begin
      for (int i = 0; i < 4; i++)
         if (edge_p0[i]) pend_ts[i] <= ts_p0;
   end

   // ---- stage p1: staged FIFO write, TOF and trigger edge ----
   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         wr_vld_p1  <= 1'b0;
         tof_vld_p1 <= 1'b0;
         trg_vld_p1 <= 1'b0;
      end else begin
         wr_vld_p1  <= arm & ~arm_rise & sel_vld;
         tof_vld_p1 <= edge_p0[1];
         trg_vld_p1 <= edge_p0[3];
      end
   end

   always_ff @(posedge rxclk) begin
      wr_chan_p1 <= sel_idx;
      wr_ts_p1   <= pend_ts[sel_idx];
      tof_p1     <= pulse_tof;
   end

   // ---- stage p2: FIFO commit, counters, outputs ----
   assign full     = (fifo_count == CW'(FIFO_DEPTH));
   assign rd_valid = (fifo_count != '0);
   assign pop      = rd_en & rd_valid;
   assign push     = wr_vld_p1 & (~full | pop);
   assign head     = mem[rptr];
   assign rd_chan  = rd_valid ? head[RW-1 -: 2] : 2'b00;
   assign rd_ts    = rd_valid ? head[TS_WIDTH-1:0] : '0;

   always_ff @(posedge rxclk) begin
      if (push) mem[wptr] <= {wr_chan_p1, wr_ts_p1};
   end

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         fifo_count  <= '0;
         overflow    <= 1'b0;
         event_count <= '0;
      end else if (arm_rise) begin
         wptr        <= '0;
         rptr        <= '0;
         fifo_count  <= '0;
         overflow    <= 1'b0;
         event_count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (pend_drop || (wr_vld_p1 && full && !pop))
            overflow <= 1'b1;
         if (push)
            event_count <= sat_inc(event_count);
      end
   end

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         tof_latched <= '0;
         trig_out    <= 1'b0;
         trig_cnt    <= '0;
      end else if (arm_rise) begin
         tof_latched <= '0;
         trig_out    <= 1'b0;
         trig_cnt    <= '0;
      end else begin
         if (tof_vld_p1)
            tof_latched <= tof_p1;
         // Retrigger simply reloads, extending the pulse from this cycle.
         if (trg_vld_p1) begin
            trig_cnt <= pulse_len(out_width);
            trig_out <= 1'b1;
         end else if (trig_cnt != '0) begin
            trig_cnt <= trig_cnt - 32'd1;
         end else begin
            trig_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trig_event_capture.sv
// Directed bench for trig_event_capture with a 4-entry FIFO.
module tb_trig_event_capture;

   localparam int TSW = 48;
   localparam int DEP = 4;
   localparam int CNW = 16;

   logic            rxclk = 1'b0;
   logic            rst;
   logic            arm;
   logic [3:0]      detect_pls;
   logic [31:0]     pulse_tof;
   logic [31:0]     out_width;
   logic            trig_out;
   logic [31:0]     tof_latched;
   logic            rd_en;
   logic            rd_valid;
   logic [1:0]      rd_chan;
   logic [TSW-1:0]  rd_ts;
   logic [2:0]      fifo_count;
   logic            overflow;
   logic [CNW-1:0]  event_count;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   trig_event_capture #(.TS_WIDTH(TSW), .FIFO_DEPTH(DEP), .CNT_WIDTH(CNW)) dut (
      .rxclk(rxclk), .rst(rst), .arm(arm), .detect_pls(detect_pls),
      .pulse_tof(pulse_tof), .out_width(out_width), .trig_out(trig_out),
      .tof_latched(tof_latched), .rd_en(rd_en), .rd_valid(rd_valid),
      .rd_chan(rd_chan), .rd_ts(rd_ts), .fifo_count(fifo_count),
      .overflow(overflow), .event_count(event_count)
   );

   always #4 rxclk = ~rxclk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge rxclk);
         cyc++;
      end
   endtask

   // Drives after this call are sampled at the edge where the DUT timestamp reads t.
   task automatic goto_ts(input int t);
      while (cyc < t + 1) step(1);
   endtask

   task automatic rearm();
      arm = 1'b0;
      detect_pls = 4'h0;
      step(2);
      arm = 1'b1;
      cyc = 0;
   endtask

   task automatic pop_expect(input string tag, input int ch, input int t);
      check_val({tag, "_vld"}, 64'(rd_valid), 64'd1);
      check_val({tag, "_chan"}, 64'(rd_chan), 64'(ch));
      check_val({tag, "_ts"}, 64'(rd_ts), 64'(t));
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
   endtask

   initial begin
      int hi;
      int rises;
      logic prev;
      rst = 1'b1; arm = 1'b0; detect_pls = 4'h0; pulse_tof = 32'h0;
      out_width = 32'd1; rd_en = 1'b0;
      step(2);
      check_val("rst_trig", 64'(trig_out), 64'd0);
      check_val("rst_vld", 64'(rd_valid), 64'd0);
      check_val("rst_cnt", 64'(fifo_count), 64'd0);
      check_val("rst_evt", 64'(event_count), 64'd0);
      rst = 1'b0;

      // Staggered single edges
      rearm();
      goto_ts(100);  detect_pls = 4'b0001;
      goto_ts(400);  detect_pls = 4'b0011;
      goto_ts(900);  detect_pls = 4'b0111;
      goto_ts(1000); detect_pls = 4'b1111;
      step(6);
      check_val("t1_cnt", 64'(fifo_count), 64'd4);
      check_val("t1_evt", 64'(event_count), 64'd4);
      check_val("t1_ovf", 64'(overflow), 64'd0);
      pop_expect("t1_r0", 0, 100);
      pop_expect("t1_r1", 1, 400);
      pop_expect("t1_r2", 2, 900);
      pop_expect("t1_r3", 3, 1000);
      check_val("t1_empty", 64'(rd_valid), 64'd0);

      // Four simultaneous edges
      rearm();
      goto_ts(50); detect_pls = 4'hF;
      step(5);
      check_val("t2_cnt_k4", 64'(fifo_count), 64'd3);
      step(1);
      check_val("t2_cnt_k5", 64'(fifo_count), 64'd4);
      for (int i = 0; i < 4; i++) pop_expect("t2_r", i, 50);
      check_val("t2_evt", 64'(event_count), 64'd4);

      // TOF latch
      rearm();
      goto_ts(20); pulse_tof = 32'h0000_1234; detect_pls = 4'b0010;
      step(1);
      pulse_tof = 32'hDEAD_BEEF;
      step(1);
      check_val("t3_tof", 64'(tof_latched), 64'h1234);
      step(3);
      check_val("t3_tof_hold", 64'(tof_latched), 64'h1234);

      // trig_out width 0, then 5 with retrigger
      rearm();
      out_width = 32'd0;
      goto_ts(10); detect_pls = 4'b1000;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (trig_out) hi++;
      end
      check_val("t4_w0_hi", 64'(hi), 64'd1);
      detect_pls = 4'h0;
      step(2);
      out_width = 32'd5;
      detect_pls = 4'b1000;
      hi = 0; rises = 0; prev = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (trig_out) hi++;
         if (trig_out && !prev) rises++;
         prev = trig_out;
         if (i == 0) detect_pls = 4'h0;
         if (i == 2) detect_pls = 4'b1000;
         if (i == 4) out_width = 32'd2;
      end
      check_val("t4_w5_hi", 64'(hi), 64'd8);
      check_val("t4_w5_rises", 64'(rises), 64'd1);

      // Overflow on a full FIFO, then re-arm
      rearm();
      out_width = 32'd1;
      goto_ts(10); detect_pls = 4'b0001;
      goto_ts(20); detect_pls = 4'b0011;
      goto_ts(30); detect_pls = 4'b0111;
      goto_ts(40); detect_pls = 4'b1111;
      goto_ts(50); detect_pls = 4'b1100;
      goto_ts(55); detect_pls = 4'b1101;
      goto_ts(60); detect_pls = 4'b1111;
      step(6);
      check_val("t5_cnt", 64'(fifo_count), 64'd4);
      check_val("t5_ovf", 64'(overflow), 64'd1);
      check_val("t5_evt", 64'(event_count), 64'd4);
      check_val("t5_head", 64'(rd_ts), 64'd10);
      rearm();
      step(1);
      check_val("t5_re_cnt", 64'(fifo_count), 64'd0);
      check_val("t5_re_ovf", 64'(overflow), 64'd0);
      check_val("t5_re_evt", 64'(event_count), 64'd0);
      goto_ts(7); detect_pls = 4'b0100;
      step(3);
      pop_expect("t5_ts0", 2, 7);

      // Async reset mid-operation
      rearm();
      out_width = 32'd100;
      goto_ts(5);  detect_pls = 4'b0001;
      goto_ts(10); detect_pls = 4'b1001;
      step(4);
      check_val("t6_cnt_pre", 64'(fifo_count), 64'd2);
      check_val("t6_trig_pre", 64'(trig_out), 64'd1);
      rst = 1'b1;
      #1;
      check_val("t6_trig", 64'(trig_out), 64'd0);
      check_val("t6_vld", 64'(rd_valid), 64'd0);
      check_val("t6_cnt", 64'(fifo_count), 64'd0);
      check_val("t6_ts", 64'(rd_ts), 64'd0);
      check_val("t6_ovf", 64'(overflow), 64'd0);
      check_val("t6_evt", 64'(event_count), 64'd0);
      check_val("t6_tof", 64'(tof_latched), 64'd0);
      step(2);
      arm = 1'b0;
      detect_pls = 4'h0;
      rst = 1'b0;
      step(3);
      check_val("t6_post_vld", 64'(rd_valid), 64'd0);
      check_val("t6_post_trig", 64'(trig_out), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
